// File: rtl/iobuf_hd_seq_if.sv
// iobuf_hd_seq_if: core handshake and pad-buffer signals of the half-duplex pad sequencer
interface iobuf_hd_seq_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              pad_i;
  logic              pad_t;
  logic              pad_o;
  modport master (output tx_data, tx_valid, pad_o, input tx_ready, rx_data, rx_valid, busy, pad_i, pad_t);
  modport slave  (input tx_data, tx_valid, pad_o, output tx_ready, rx_data, rx_valid, busy, pad_i, pad_t);
endinterface

// File: rtl/iobuf_hd_seq.sv
// iobuf_hd_seq: drives a word out on a bidirectional pad, turns the bus around and captures the reply word
module iobuf_hd_seq #(
  parameter int DATA_W   = 8,
  parameter int BIT_CYC  = 4,
  parameter int TURN_CYC = 2
) (
  input logic            clk,
  input logic            rst_n,
  iobuf_hd_seq_if.slave  bus
);
  localparam int MX = (BIT_CYC > TURN_CYC) ? ((BIT_CYC > DATA_W) ? BIT_CYC : DATA_W)
                                           : ((TURN_CYC > DATA_W) ? TURN_CYC : DATA_W);
  localparam int CW = $clog2(MX);
  typedef enum logic [2:0] {IDLE, DRIVE, TURN1, RECV, TURN2} state_t;
  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx, idx, idx_nx;
  logic [DATA_W-1:0] tx_sr, tx_nx, rx_sr, rx_nx;
  logic              bit_end, turn_end, last_bit, mid;
  assign bus.tx_ready = state == IDLE;
  assign bus.busy     = state != IDLE;
  // next state, counters and shift registers; counters restart on every state change
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    tx_nx    = tx_sr;
    rx_nx    = rx_sr;
    bit_end  = cnt == CW'(BIT_CYC - 1);
    turn_end = cnt == CW'(TURN_CYC - 1);
    last_bit = idx == CW'(DATA_W - 1);
    mid      = cnt == CW'(BIT_CYC / 2);
    case (state)
      IDLE: begin
        cnt_nx = '0;
        idx_nx = '0;
        if (bus.tx_valid) begin
          state_nx = DRIVE;
          tx_nx    = bus.tx_data;
        end
      end
      DRIVE: if (bit_end) begin
        cnt_nx   = '0;
        idx_nx   = last_bit ? '0 : idx + CW'(1);
        tx_nx    = tx_sr << 1;
        state_nx = last_bit ? TURN1 : DRIVE;
      end
      TURN1: if (turn_end) begin
        cnt_nx   = '0;
        state_nx = RECV;
      end
      RECV: begin
        if (mid) rx_nx = DATA_W'({rx_sr, bus.pad_o});
        if (bit_end) begin
          cnt_nx   = '0;
          idx_nx   = last_bit ? '0 : idx + CW'(1);
          state_nx = last_bit ? TURN2 : RECV;
        end
      end
      TURN2: if (turn_end) begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state and datapath registers; pad controls are registered from the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.pad_t    <= 1'b1;
      bus.pad_i    <= 1'b1;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      tx_sr        <= tx_nx;
      rx_sr        <= rx_nx;
      bus.rx_valid <= state == RECV && state_nx == TURN2;
      if (state == RECV && state_nx == TURN2) bus.rx_data <= rx_nx;
      bus.pad_t    <= state_nx != DRIVE;
      bus.pad_i    <= state_nx != DRIVE || tx_nx[DATA_W-1];
    end
  end
endmodule
